// File: rtl/lfsr_arb_pkg.sv
// Shared types and constants for the LFSR arbiter slice.
// Provides the FSM state enum, the default seed and a zero-seed fixup helper.
package lfsr_arb_pkg;

  localparam int LFSR_W = 32;

  localparam logic [LFSR_W-1:0] SEED_DEFAULT = 32'h0000_0001;

  typedef enum logic [2:0] {
    ST_RST,
    ST_LOAD,
    ST_IDLE,
    ST_COLLECT,
    ST_DONE
  } state_t;

  // An all-zero seed would lock the LFSR up, so it maps to the default.
  function automatic logic [LFSR_W-1:0] seed_fix(
    input logic [LFSR_W-1:0] s
  );
    return (s == '0) ? SEED_DEFAULT : s;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: search starts at i_ptr+1 and wraps.
// Ports: i_req (requests), i_ptr (last winner), o_gnt (one-hot), o_idx, o_any.
module rr_arbiter
  import lfsr_arb_pkg::*;
#(
  parameter  int NREQ  = 4,
  localparam int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_gnt,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_any
);

  function automatic logic [PTR_W-1:0] wrap(
    input logic [PTR_W-1:0] p,
    input int               k
  );
    return PTR_W'((int'(p) + k) % NREQ);
  endfunction

  always_comb begin
    o_gnt = '0;
    o_idx = i_ptr;
    o_any = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!o_any && i_req[wrap(i_ptr, k)]) begin
        o_any                 = 1'b1;
        o_gnt[wrap(i_ptr, k)] = 1'b1;
        o_idx                 = wrap(i_ptr, k);
      end
    end
  end

endmodule

// File: rtl/lfsr_arbiter.sv
// Shares one serial LFSR between NREQ requesters: sequences its reset and
// seed load, grants round-robin and packs WIDTH bits into a word per grant.
// Ports: i_clk, i_reset_n (async, low); i_req/o_gnt/o_valid/o_data consumer
// side; i_seed/i_seed_wr seed update; o_lfsr_rst/o_lfsr_load/o_lfsr_seed and
// i_lfsr_bit LFSR side; o_busy high outside IDLE.
// Optional macro LFSR_ARB_RESEED_EN: automatic reseed every RESEED_COUNT words.
module lfsr_arbiter
  import lfsr_arb_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int WIDTH        = 8,
  parameter int RESEED_COUNT = 256
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [NREQ-1:0]   i_req,
  output logic [NREQ-1:0]   o_gnt,
  output logic [NREQ-1:0]   o_valid,
  output logic [WIDTH-1:0]  o_data,
  input  logic [LFSR_W-1:0] i_seed,
  input  logic              i_seed_wr,
  output logic              o_lfsr_rst,
  output logic              o_lfsr_load,
  output logic [LFSR_W-1:0] o_lfsr_seed,
  input  logic              i_lfsr_bit,
  output logic              o_busy
);

  localparam int PTR_W  = $clog2(NREQ);
  localparam int BCNT_W = $clog2(WIDTH + 1);

  state_t             r_state, w_state_nxt;
  logic [LFSR_W-1:0]  r_seed, w_seed_nxt;
  logic [LFSR_W-1:0]  r_pend, w_pend_nxt;
  logic               r_pend_vld, w_pend_vld_nxt;
  logic [PTR_W-1:0]   r_ptr, w_ptr_nxt;
  logic [NREQ-1:0]    r_gnt, w_gnt_nxt;
  logic [NREQ-1:0]    r_valid, w_valid_nxt;
  logic [WIDTH-1:0]   r_data, w_data_nxt;
  logic [WIDTH-1:0]   r_shreg, w_shreg_nxt;
  logic [BCNT_W-1:0]  r_bcnt, w_bcnt_nxt;
  logic               r_lfsr_rst, w_lfsr_rst_nxt;
  logic               r_lfsr_load, w_lfsr_load_nxt;
  logic [LFSR_W-1:0]  r_lfsr_seed, w_lfsr_seed_nxt;
  logic               r_busy;

  logic [NREQ-1:0]    w_pick;
  logic [PTR_W-1:0]   w_pick_idx;
  logic               w_any;

`ifdef LFSR_ARB_RESEED_EN
  localparam int RCNT_W = $clog2(RESEED_COUNT + 1);
  logic [RCNT_W-1:0]  r_rcnt, w_rcnt_nxt;
`else
  localparam int unused_reseed_count = RESEED_COUNT;
`endif

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_gnt (w_pick),
    .o_idx (w_pick_idx),
    .o_any (w_any)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_seed_nxt      = r_seed;
    w_pend_nxt      = r_pend;
    w_pend_vld_nxt  = r_pend_vld;
    w_ptr_nxt       = r_ptr;
    w_gnt_nxt       = r_gnt;
    w_valid_nxt     = '0;
    w_data_nxt      = r_data;
    w_shreg_nxt     = r_shreg;
    w_bcnt_nxt      = r_bcnt;
    w_lfsr_rst_nxt  = 1'b0;
    w_lfsr_load_nxt = 1'b0;
    w_lfsr_seed_nxt = r_lfsr_seed;
`ifdef LFSR_ARB_RESEED_EN
    w_rcnt_nxt      = r_rcnt;
`endif

    // Seed writes are parked in any state; IDLE consumes them.
    if (i_seed_wr) begin
      w_pend_nxt     = seed_fix(i_seed);
      w_pend_vld_nxt = 1'b1;
    end

    unique case (r_state)
      ST_RST: begin
        w_lfsr_rst_nxt = 1'b1;
        w_state_nxt    = ST_LOAD;
      end
      ST_LOAD: begin
        w_lfsr_load_nxt = 1'b1;
        w_lfsr_seed_nxt = r_seed;
        w_state_nxt     = ST_IDLE;
      end
      ST_IDLE: begin
        // A same-cycle write is newer than any parked one.
        if (i_seed_wr || r_pend_vld) begin
          w_seed_nxt     = i_seed_wr ? seed_fix(i_seed) : r_pend;
          w_pend_vld_nxt = 1'b0;
          w_state_nxt    = ST_LOAD;
        end else if (w_any) begin
          w_gnt_nxt   = w_pick;
          w_ptr_nxt   = w_pick_idx;
          w_bcnt_nxt  = '0;
          w_state_nxt = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if ((r_gnt & i_req) == '0) begin
          w_gnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          // First sampled bit ends up in the MSB.
          w_shreg_nxt = WIDTH'({r_shreg, i_lfsr_bit});
          w_bcnt_nxt  = r_bcnt + 1'b1;
          if (r_bcnt == BCNT_W'(WIDTH - 1))
            w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_data_nxt  = r_shreg;
        w_valid_nxt = r_gnt;
        w_gnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
`ifdef LFSR_ARB_RESEED_EN
        if (r_rcnt == RCNT_W'(RESEED_COUNT - 1)) begin
          w_rcnt_nxt  = '0;
          w_seed_nxt  = {r_seed[LFSR_W-2:0], r_seed[LFSR_W-1]};
          w_state_nxt = ST_LOAD;
        end else begin
          w_rcnt_nxt = r_rcnt + 1'b1;
        end
`endif
      end
      default: w_state_nxt = ST_RST;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= ST_RST;
      r_seed      <= SEED_DEFAULT;
      r_pend      <= SEED_DEFAULT;
      r_pend_vld  <= 1'b0;
      r_ptr       <= PTR_W'(NREQ - 1);
      r_gnt       <= '0;
      r_valid     <= '0;
      r_data      <= '0;
      r_shreg     <= '0;
      r_bcnt      <= '0;
      r_lfsr_rst  <= 1'b0;
      r_lfsr_load <= 1'b0;
      r_lfsr_seed <= SEED_DEFAULT;
      r_busy      <= 1'b0;
`ifdef LFSR_ARB_RESEED_EN
      r_rcnt      <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_seed      <= w_seed_nxt;
      r_pend      <= w_pend_nxt;
      r_pend_vld  <= w_pend_vld_nxt;
      r_ptr       <= w_ptr_nxt;
      r_gnt       <= w_gnt_nxt;
      r_valid     <= w_valid_nxt;
      r_data      <= w_data_nxt;
      r_shreg     <= w_shreg_nxt;
      r_bcnt      <= w_bcnt_nxt;
      r_lfsr_rst  <= w_lfsr_rst_nxt;
      r_lfsr_load <= w_lfsr_load_nxt;
      r_lfsr_seed <= w_lfsr_seed_nxt;
      // Registered so busy reads low while reset is held.
      r_busy      <= (w_state_nxt != ST_IDLE);
`ifdef LFSR_ARB_RESEED_EN
      r_rcnt      <= w_rcnt_nxt;
`endif
    end
  end

  assign o_gnt       = r_gnt;
  assign o_valid     = r_valid;
  assign o_data      = r_data;
  assign o_lfsr_rst  = r_lfsr_rst;
  assign o_lfsr_load = r_lfsr_load;
  assign o_lfsr_seed = r_lfsr_seed;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_lfsr_arbiter.sv
// Directed bench for lfsr_arbiter (NREQ=4, WIDTH=8, RESEED_COUNT=2).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_lfsr_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   valid;
  logic [WIDTH-1:0]  data;
  logic [31:0]       seed;
  logic              seed_wr;
  logic              lrst;
  logic              lload;
  logic [31:0]       lseed;
  logic              lbit;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;

  lfsr_arbiter #(
    .NREQ         (NREQ),
    .WIDTH        (WIDTH),
    .RESEED_COUNT (2)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_req       (req),
    .o_gnt       (gnt),
    .o_valid     (valid),
    .o_data      (data),
    .i_seed      (seed),
    .i_seed_wr   (seed_wr),
    .o_lfsr_rst  (lrst),
    .o_lfsr_load (lload),
    .o_lfsr_seed (lseed),
    .i_lfsr_bit  (lbit),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: timeout, got no end, want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(negedge clk);
  endtask

  // Leaves the DUT in IDLE at the falling edge after edge 2.
  task automatic do_reset;
    rst_n   = 1'b0;
    req     = '0;
    seed    = '0;
    seed_wr = 1'b0;
    lbit    = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
  endtask

  // Drives bits MSB first, one per cycle.
  task automatic feed(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      lbit = b[i];
      tick();
    end
  endtask

  task automatic test_reset;
    rst_n   = 1'b0;
    req     = '0;
    seed    = '0;
    seed_wr = 1'b0;
    lbit    = 1'b0;
    tick();
    n_tests++;
    if ({gnt, valid, data, lrst, lload, busy} !== '0) begin
      n_fail++;
      $display("FAIL rst_outs: got gnt=%b val=%b d=%h r=%b l=%b b=%b want 0",
               gnt, valid, data, lrst, lload, busy);
    end
    n_tests++;
    if (lseed !== 32'h1) begin
      n_fail++;
      $display("FAIL rst_seed: got %h want 00000001", lseed);
    end
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (lrst !== 1'b1 || lload !== 1'b0) begin
      n_fail++;
      $display("FAIL edge1: got rst=%b load=%b want 1 0", lrst, lload);
    end
    tick();
    n_tests++;
    if (lrst !== 1'b0 || lload !== 1'b1 || lseed !== 32'h1) begin
      n_fail++;
      $display("FAIL edge2: got rst=%b load=%b seed=%h want 0 1 00000001",
               lrst, lload, lseed);
    end
    tick();
    n_tests++;
    if ({gnt, valid, lrst, lload, busy} !== '0) begin
      n_fail++;
      $display("FAIL edge3_idle: got gnt=%b val=%b r=%b l=%b b=%b want 0",
               gnt, valid, lrst, lload, busy);
    end
  endtask

  task automatic test_single;
    do_reset();
    req = 4'b0001;
    tick();
    n_tests++;
    if (gnt !== 4'b0001 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_gnt: got gnt=%b busy=%b want 0001 1", gnt, busy);
    end
    feed(8'hB2);
    n_tests++;
    if (valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_early: got valid=%b want 0000", valid);
    end
    tick();
    n_tests++;
    if (valid !== 4'b0001 || data !== 8'hB2 || gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_done: got v=%b d=%h g=%b want 0001 b2 0000",
               valid, data, gnt);
    end
    req = '0;
    tick();
    n_tests++;
    if (valid !== 4'b0000 || data !== 8'hB2 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_after: got v=%b d=%h b=%b want 0000 b2 0",
               valid, data, busy);
    end
  endtask

  task automatic test_round_robin;
    logic [NREQ-1:0] exp_g;
    logic [7:0]      exp_d;
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      exp_d = (k % 2 == 0) ? 8'hFF : 8'h00;
      lbit  = (k % 2 == 0);
      tick();
      n_tests++;
      if (gnt !== exp_g) begin
        n_fail++;
        $display("FAIL rr_gnt%0d: got %b want %b", k, gnt, exp_g);
      end
      repeat (8) tick();
      tick();
      n_tests++;
      if (valid !== exp_g || data !== exp_d) begin
        n_fail++;
        $display("FAIL rr_word%0d: got v=%b d=%h want %b %h",
                 k, valid, data, exp_g, exp_d);
      end
    end
    req = '0;
    tick();
  endtask

  task automatic test_seed;
    logic saw_load;
    do_reset();
    seed    = 32'h1234_5678;
    seed_wr = 1'b1;
    tick();
    seed_wr = 1'b0;
    n_tests++;
    if (lload !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL seed_goload: got load=%b busy=%b want 0 1", lload, busy);
    end
    tick();
    n_tests++;
    if (lload !== 1'b1 || lseed !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL seed_apply: got load=%b seed=%h want 1 12345678",
               lload, lseed);
    end
    req = 4'b0001;
    tick();
    n_tests++;
    if (gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL seed_gnt: got %b want 0001", gnt);
    end
    saw_load = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      lbit    = 8'h5A >> i;
      seed_wr = (i == 6) || (i == 4);
      seed    = (i == 6) ? 32'hDEAD_BEEF : 32'h0;
      tick();
      saw_load |= lload;
    end
    seed_wr = 1'b0;
    tick();
    saw_load |= lload;
    n_tests++;
    if (valid !== 4'b0001 || data !== 8'h5A || saw_load !== 1'b0) begin
      n_fail++;
      $display("FAIL seed_word: got v=%b d=%h load=%b want 0001 5a 0",
               valid, data, saw_load);
    end
    tick();
    n_tests++;
    if (gnt !== 4'b0000 || lload !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL seed_wins: got g=%b l=%b b=%b want 0000 0 1",
               gnt, lload, busy);
    end
    tick();
    n_tests++;
    if (lload !== 1'b1 || lseed !== 32'h1 || gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL seed_zero: got l=%b s=%h g=%b want 1 00000001 0000",
               lload, lseed, gnt);
    end
    tick();
    n_tests++;
    if (gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL seed_regnt: got %b want 0001", gnt);
    end
    req = '0;
    tick();
  endtask

  task automatic test_abort;
    do_reset();
    req = 4'b0001;
    tick();
    feed(8'hB2);
    tick();
    n_tests++;
    if (valid !== 4'b0001 || data !== 8'hB2) begin
      n_fail++;
      $display("FAIL abort_pre: got v=%b d=%h want 0001 b2", valid, data);
    end
    req = 4'b1100;
    tick();
    n_tests++;
    if (gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL abort_gnt: got %b want 0100", gnt);
    end
    lbit = 1'b1;
    tick();
    tick();
    req = 4'b1000;
    tick();
    n_tests++;
    if (gnt !== 4'b0000 || valid !== 4'b0000 || data !== 8'hB2 ||
        busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_drop: got g=%b v=%b d=%h b=%b want 0 0 b2 0",
               gnt, valid, data, busy);
    end
    tick();
    n_tests++;
    if (gnt !== 4'b1000 || valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL abort_next: got g=%b v=%b want 1000 0000", gnt, valid);
    end
    req = '0;
    tick();
  endtask

  task automatic test_reset_mid;
    do_reset();
    req = 4'b0001;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({gnt, valid, busy, lrst, lload} !== '0 || lseed !== 32'h1) begin
      n_fail++;
      $display("FAIL rstmid_clear: got g=%b v=%b b=%b s=%h want 0 0 0 1",
               gnt, valid, busy, lseed);
    end
    tick();
    rst_n = 1'b1;
    req   = '0;
    tick();
    n_tests++;
    if (lrst !== 1'b1 || valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL rstmid_rst: got rst=%b v=%b want 1 0000", lrst, valid);
    end
    tick();
    n_tests++;
    if (lload !== 1'b1 || lseed !== 32'h1) begin
      n_fail++;
      $display("FAIL rstmid_load: got l=%b s=%h want 1 00000001",
               lload, lseed);
    end
  endtask

  task automatic test_reseed;
    do_reset();
    seed    = 32'h8000_0001;
    seed_wr = 1'b1;
    tick();
    seed_wr = 1'b0;
    tick();
    n_tests++;
    if (lload !== 1'b1 || lseed !== 32'h8000_0001) begin
      n_fail++;
      $display("FAIL reseed_init: got l=%b s=%h want 1 80000001",
               lload, lseed);
    end
    req = 4'b0001;
    tick();
    feed(8'h00);
    tick();
    tick();
    n_tests++;
    if (gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL reseed_w2gnt: got %b want 0001", gnt);
    end
    feed(8'h00);
    tick();
    n_tests++;
    if (valid !== 4'b0001) begin
      n_fail++;
      $display("FAIL reseed_w2: got v=%b want 0001", valid);
    end
    req = '0;
    tick();
    n_tests++;
`ifdef LFSR_ARB_RESEED_EN
    if (lload !== 1'b1 || lseed !== 32'h0000_0003) begin
      n_fail++;
      $display("FAIL reseed_load: got l=%b s=%h want 1 00000003",
               lload, lseed);
    end
`else
    if (lload !== 1'b0 || lseed !== 32'h8000_0001 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reseed_off: got l=%b s=%h b=%b want 0 80000001 0",
               lload, lseed, busy);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_seed();
    test_abort();
    test_reset_mid();
    test_reseed();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
